// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_pkg
// Description : Shared SRAM bus widths, latency bounds and access decoding.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_pkg;

    localparam int c_data_bits           = 16;
    localparam int c_addr_bits           = 18;
    localparam int c_count_bits          = 16;
    localparam int c_read_latency_min    = 1;
    localparam int c_read_latency_max    = 4;
    localparam int c_read_latency_dflt   = 2;

    typedef enum logic [1:0] {
        ACC_IDLE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2
    } access_e;

    // Write wins over read whenever WE_N is low; OE_N only qualifies reads.
    function automatic access_e decode_access(input logic ce_n,
                                              input logic we_n,
                                              input logic oe_n);
        access_e acc;
        acc = ACC_IDLE;
        if (!ce_n) begin
            if (!we_n) begin
                acc = ACC_WRITE;
            end else if (!oe_n) begin
                acc = ACC_READ;
            end
        end
        return acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_responder_if
// Description : SRAM address/control strobes shared by initiator and responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_responder_if;
    import sram_pkg::*;

    logic [c_addr_bits-1:0] SRAM_ADDR;
    logic                   SRAM_WE_N;
    logic                   SRAM_CE_N;
    logic                   SRAM_OE_N;
    logic                   SRAM_UB_N;
    logic                   SRAM_LB_N;

    modport master (
        output SRAM_ADDR, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N
    );

    modport slave (
        input  SRAM_ADDR, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N
    );

endinterface
`default_nettype wire

// File: rtl/sram_read_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sram_read_pipe
// Description : Fixed-depth valid/data delay line for SRAM read responses.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_read_pipe #(
    parameter int DEPTH     = 2,
    parameter int DATA_BITS = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 i_valid,
    input  wire logic [DATA_BITS-1:0] i_data,
    output logic                      o_valid,
    output logic [DATA_BITS-1:0]      o_data
);

    logic [DEPTH-1:0]     r_valid;
    logic [DATA_BITS-1:0] r_data [DEPTH];

    // Only the valid bits need clearing; stale data behind a cleared valid is harmless.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
        end else begin
            r_valid[0] <= i_valid;
            for (int k = 1; k < DEPTH; k++) begin
                r_valid[k] <= r_valid[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_data[0] <= i_data;
        for (int k = 1; k < DEPTH; k++) begin
            r_data[k] <= r_data[k-1];
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_data  = r_data[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : sram_responder
// Description : Behavioural 16-bit SRAM with byte lanes and pipelined reads.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_responder
    import sram_pkg::*;
#(
    parameter int ADDR_BITS    = c_addr_bits,
    parameter int READ_LATENCY = c_read_latency_dflt
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    sram_responder_if.slave              bus,
    inout  wire [c_data_bits-1:0]        SRAM_DQ,
    output logic [c_count_bits-1:0]      rd_count,
    output logic [c_count_bits-1:0]      wr_count
);

    access_e                w_access;
    logic [ADDR_BITS-1:0]   w_idx;
    logic [c_data_bits-1:0] w_rd_word;
    logic                   w_out_valid;
    logic [c_data_bits-1:0] w_out_data;
    logic [1:0]             w_lane_en;
    logic [1:0]             w_dq_oe;
    logic                   w_unused_addr;

    logic [7:0] r_mem_hi [2**ADDR_BITS];
    logic [7:0] r_mem_lo [2**ADDR_BITS];

    assign w_access      = decode_access(bus.SRAM_CE_N, bus.SRAM_WE_N, bus.SRAM_OE_N);
    assign w_idx         = bus.SRAM_ADDR[ADDR_BITS-1:0];
    assign w_unused_addr = ^bus.SRAM_ADDR;
    assign w_lane_en     = {~bus.SRAM_UB_N, ~bus.SRAM_LB_N};

    // Storage is not reset; rst only gates sampling so no write lands while held.
    always_ff @(posedge clk) begin
        if (rst && (w_access == ACC_WRITE)) begin
            if (w_lane_en[1]) begin
                r_mem_hi[w_idx] <= SRAM_DQ[15:8];
            end
            if (w_lane_en[0]) begin
                r_mem_lo[w_idx] <= SRAM_DQ[7:0];
            end
        end
    end

    assign w_rd_word = {r_mem_hi[w_idx], r_mem_lo[w_idx]};

    sram_read_pipe #(
        .DEPTH     (READ_LATENCY),
        .DATA_BITS (c_data_bits)
    ) u_read_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_access == ACC_READ),
        .i_data  (w_rd_word),
        .o_valid (w_out_valid),
        .o_data  (w_out_data)
    );

    // The drive qualifier is exactly the read-access decode, so WE_N=0 never drives.
    assign w_dq_oe = {2{w_out_valid && (w_access == ACC_READ)}} & w_lane_en;

    for (genvar g = 0; g < 2; g++) begin : g_lane
        assign SRAM_DQ[g*8 +: 8] = w_dq_oe[g] ? w_out_data[g*8 +: 8] : 8'bz;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (w_out_valid) begin
                rd_count <= rd_count + 16'd1;
            end
            if (w_access == ACC_WRITE) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire
